controller: RTL and testbench

CONTROLLER -- requirements
Module: controller

---
 rtl/controller_pkg.sv | 42 ++++
 rtl/program_counter.sv | 28 ++
 rtl/controller.sv | 135 +++++++++++++
 tb/tb_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared definitions for the controller: opcodes, state codes, ALU selects
// and the bundle of datapath control signals.
package controller_pkg;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    // All datapath control outputs, registered together in the controller.
    typedef struct packed {
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] rf_w_addr;
        logic       rf_w_wr;
        logic [3:0] rf_ra_addr;
        logic       rf_ra_rd;
        logic [3:0] rf_rb_addr;
        logic       rf_rb_rd;
        logic [2:0] alu_s0;
    } ctrl_t;

endpackage

// File: rtl/program_counter.sv
// Program counter: clears on reset, increments by one when enabled and
// wraps naturally modulo 2^PC_W.
module program_counter #(
    parameter int PC_W = 7
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_en,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_one;

    assign w_one = {{(PC_W-1){1'b0}}, 1'b1};

    // PC register; the all-ones value rolls over to zero on increment
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= '0;
        end else if (i_en) begin
            r_pc <= r_pc + w_one;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/controller.sv
// Multi-cycle CPU controller: fetch/decode/execute sequencer driving the
// instruction ROM address, the register file, the ALU and the data RAM.
// Control outputs are registered from the next state and the IR value that
// will be in effect, so they behave as Moore outputs of the current state.
module controller
    import controller_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [15:0]     Instr_in,
    output logic [PC_W-1:0] PC_out,
    output logic [15:0]     IR_out,
    output logic [3:0]      State_out,
    output logic [7:0]      D_addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_wr,
    output logic [3:0]      RF_Ra_addr,
    output logic            RF_Ra_rd,
    output logic [3:0]      RF_Rb_addr,
    output logic            RF_Rb_rd,
    output logic [2:0]      Alu_s0
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_ir;
    logic [15:0] w_ir_next;
    ctrl_t       r_ctrl;
    ctrl_t       w_ctrl_next;
    logic        w_pc_en;

    // The PC advances only while fetching
    assign w_pc_en = (r_state == S_FETCH);

    program_counter #(
        .PC_W (PC_W)
    ) u_pc (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_en    (w_pc_en),
        .o_pc    (PC_out)
    );

    // IR captures ROM data in FETCH and holds otherwise
    assign w_ir_next = (r_state == S_FETCH) ? Instr_in : r_ir;

    // Next-state sequencing; unknown opcodes fall through to NOOP
    always_comb begin
        w_state_next = S_INIT;
        case (r_state)
            S_INIT:   w_state_next = S_FETCH;
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: begin
                case (r_ir[15:12])
                    OP_STORE: w_state_next = S_STORE;
                    OP_LOAD:  w_state_next = S_LOAD_A;
                    OP_ADD:   w_state_next = S_ADD;
                    OP_SUB:   w_state_next = S_SUB;
                    OP_HALT:  w_state_next = S_HALT;
                    default:  w_state_next = S_NOOP;
                endcase
            end
            S_LOAD_A: w_state_next = S_LOAD_B;
            S_LOAD_B: w_state_next = S_FETCH;
            S_STORE:  w_state_next = S_FETCH;
            S_ADD:    w_state_next = S_FETCH;
            S_SUB:    w_state_next = S_FETCH;
            S_NOOP:   w_state_next = S_FETCH;
            S_HALT:   w_state_next = S_HALT;
            default:  w_state_next = S_INIT;
        endcase
    end

    // Output decode for the upcoming state; anything not driven stays zero
    always_comb begin
        w_ctrl_next = '0;
        case (w_state_next)
            S_LOAD_A, S_LOAD_B: begin
                w_ctrl_next.d_addr    = w_ir_next[11:4];
                w_ctrl_next.rf_s      = 1'b1;
                w_ctrl_next.rf_w_addr = w_ir_next[3:0];
                // LOAD_A only waits out the RAM read latency
                w_ctrl_next.rf_w_wr   = (w_state_next == S_LOAD_B);
            end
            S_STORE: begin
                w_ctrl_next.d_addr     = w_ir_next[11:4];
                w_ctrl_next.rf_ra_addr = w_ir_next[3:0];
                w_ctrl_next.rf_ra_rd   = 1'b1;
                w_ctrl_next.d_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                w_ctrl_next.rf_ra_addr = w_ir_next[11:8];
                w_ctrl_next.rf_ra_rd   = 1'b1;
                w_ctrl_next.rf_rb_addr = w_ir_next[7:4];
                w_ctrl_next.rf_rb_rd   = 1'b1;
                w_ctrl_next.alu_s0     = (w_state_next == S_ADD) ? ALU_ADD : ALU_SUB;
                w_ctrl_next.rf_s       = 1'b0;
                w_ctrl_next.rf_w_addr  = w_ir_next[3:0];
                w_ctrl_next.rf_w_wr    = 1'b1;
            end
            default: w_ctrl_next = '0;
        endcase
    end

    // State, IR and control registers; reset drops every enable at once
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_INIT;
            r_ir    <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ir    <= w_ir_next;
            r_ctrl  <= w_ctrl_next;
        end
    end

    assign IR_out     = r_ir;
    assign State_out  = r_state;
    assign D_addr     = r_ctrl.d_addr;
    assign D_wr       = r_ctrl.d_wr;
    assign RF_s       = r_ctrl.rf_s;
    assign RF_W_addr  = r_ctrl.rf_w_addr;
    assign RF_W_wr    = r_ctrl.rf_w_wr;
    assign RF_Ra_addr = r_ctrl.rf_ra_addr;
    assign RF_Ra_rd   = r_ctrl.rf_ra_rd;
    assign RF_Rb_addr = r_ctrl.rf_rb_addr;
    assign RF_Rb_rd   = r_ctrl.rf_rb_rd;
    assign Alu_s0     = r_ctrl.alu_s0;

endmodule

// File: tb/tb_controller.sv
// Testbench for controller: an instruction-level reference model expands the
// ROM program into the expected per-cycle state/PC/IR/control trace.
module tb_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr1 = '0;
    logic [15:0] instr2 = '0;
    logic [15:0] rom [0:127];

    // PC_W = 7 instance outputs
    logic [6:0]  pc1;
    logic [15:0] ir1;
    logic [3:0]  st1, wa1, ra1, rb1;
    logic [7:0]  da1;
    logic        dwr1, rfs1, wwr1, rard1, rbrd1;
    logic [2:0]  alu1;
    // PC_W = 2 instance outputs
    logic [1:0]  pc2;
    logic [15:0] ir2;
    logic [3:0]  st2, wa2, ra2, rb2;
    logic [7:0]  da2;
    logic        dwr2, rfs2, wwr2, rard2, rbrd2;
    logic [2:0]  alu2;

    int n_chk = 0;
    int n_err = 0;
    int sel = 0;

    logic [3:0]  obs_st;
    logic [6:0]  obs_pc;
    logic [15:0] obs_ir;
    logic [27:0] obs_ctl;

    typedef struct {
        int          st;
        int          pc;
        logic [15:0] ir;
        logic [27:0] ctl;
    } rec_t;
    rec_t expq[$];

    always #5 clk = ~clk;

    // Synchronous instruction ROMs, one-cycle latency
    always @(posedge clk) begin
        instr1 <= rom[pc1];
        instr2 <= rom[{5'd0, pc2}];
    end

    controller #(.PC_W(7)) dut (
        .Clock(clk), .Reset(rst_n), .Instr_in(instr1), .PC_out(pc1), .IR_out(ir1),
        .State_out(st1), .D_addr(da1), .D_wr(dwr1), .RF_s(rfs1), .RF_W_addr(wa1),
        .RF_W_wr(wwr1), .RF_Ra_addr(ra1), .RF_Ra_rd(rard1), .RF_Rb_addr(rb1),
        .RF_Rb_rd(rbrd1), .Alu_s0(alu1)
    );

    controller #(.PC_W(2)) dut2 (
        .Clock(clk), .Reset(rst_n), .Instr_in(instr2), .PC_out(pc2), .IR_out(ir2),
        .State_out(st2), .D_addr(da2), .D_wr(dwr2), .RF_s(rfs2), .RF_W_addr(wa2),
        .RF_W_wr(wwr2), .RF_Ra_addr(ra2), .RF_Ra_rd(rard2), .RF_Rb_addr(rb2),
        .RF_Rb_rd(rbrd2), .Alu_s0(alu2)
    );

    always_comb begin
        obs_st  = st1;
        obs_pc  = pc1;
        obs_ir  = ir1;
        obs_ctl = {da1, dwr1, rfs1, wa1, wwr1, ra1, rard1, rb1, rbrd1, alu1};
        if (sel == 1) begin
            obs_st  = st2;
            obs_pc  = {5'd0, pc2};
            obs_ir  = ir2;
            obs_ctl = {da2, dwr2, rfs2, wa2, wwr2, ra2, rard2, rb2, rbrd2, alu2};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] mk(input logic [7:0] da, input logic dwr, input logic rfs,
                                       input logic [3:0] wa, input logic wwr, input logic [3:0] ra,
                                       input logic rard, input logic [3:0] rb, input logic rbrd,
                                       input logic [2:0] alu);
        return {da, dwr, rfs, wa, wwr, ra, rard, rb, rbrd, alu};
    endfunction

    function automatic void push(input int st, input int pc, input logic [15:0] ir,
                                 input logic [27:0] ctl);
        rec_t r;
        r.st = st; r.pc = pc; r.ir = ir; r.ctl = ctl;
        expq.push_back(r);
    endfunction

    // Instruction-level model: each instruction becomes FETCH, DECODE and its
    // execute cycle(s); HALT repeats forever.
    function automatic void build_model(input int w, input int ncyc);
        int pc;
        int mask;
        logic [15:0] ir;
        mask = (1 << w) - 1;
        expq.delete();
        pc = 0;
        ir = '0;
        push(0, pc, ir, '0);
        while (expq.size() < ncyc) begin
            push(1, pc, ir, '0);
            ir = rom[pc];
            pc = (pc + 1) & mask;
            push(2, pc, ir, '0);
            case (int'(ir[15:12]))
                1: push(6, pc, ir, mk(ir[11:4], 1'b1, 1'b0, 4'd0, 1'b0, ir[3:0], 1'b1, 4'd0, 1'b0, 3'd0));
                2: begin
                    push(4, pc, ir, mk(ir[11:4], 1'b0, 1'b1, ir[3:0], 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0));
                    push(5, pc, ir, mk(ir[11:4], 1'b0, 1'b1, ir[3:0], 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 3'd0));
                end
                3: push(7, pc, ir, mk(8'd0, 1'b0, 1'b0, ir[3:0], 1'b1, ir[11:8], 1'b1, ir[7:4], 1'b1, 3'd1));
                4: push(8, pc, ir, mk(8'd0, 1'b0, 1'b0, ir[3:0], 1'b1, ir[11:8], 1'b1, ir[7:4], 1'b1, 3'd2));
                5: while (expq.size() < ncyc) push(9, pc, ir, '0);
                default: push(3, pc, ir, '0);
            endcase
        end
    endfunction

    // Hold reset over a few edges, release it at a falling edge
    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Compare one cycle per falling edge, starting right at reset release
    task automatic run_trace(input string name, input int w, input int ncyc);
        rec_t r;
        build_model(w, ncyc);
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk);
            r = expq[i];
            chk($sformatf("%s c%0d state", name, i), obs_st, r.st);
            chk($sformatf("%s c%0d pc", name, i), obs_pc, r.pc);
            chk($sformatf("%s c%0d ir", name, i), obs_ir, r.ir);
            chk($sformatf("%s c%0d ctl", name, i), obs_ctl, r.ctl);
            $display("%s cycle %0d: state=%0d pc=%0d ir=%h ctl=%h", name, i, obs_st, obs_pc, obs_ir, obs_ctl);
        end
    endtask

    initial begin
        int found;
        logic [31:0] rnd;
        logic [3:0] op;

        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;

        // Reset state
        rst_n = 1'b0;
        #12;
        chk("reset state", obs_st, 0);
        chk("reset pc", obs_pc, 0);
        chk("reset ctl", obs_ctl, 0);

        // Directed program: LOAD, ADD, STORE, SUB, HALT
        rom[0] = 16'h2055; rom[1] = 16'h3562; rom[2] = 16'h1802;
        rom[3] = 16'h4123; rom[4] = 16'h5000;
        apply_reset();
        run_trace("prog", 7, 38);
        chk("halt pc", obs_pc, 5);
        chk("halt state", obs_st, 9);

        // Reset pulse during LOAD_A, then restart from address 0
        for (int i = 5; i < 128; i++) begin
            rnd = $urandom;
            rom[i] = rnd[15:0];
        end
        apply_reset();
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            @(negedge clk);
            if (obs_st == 4'd4) found = 1;
        end
        chk("wait load_a", found, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset state", obs_st, 0);
        chk("midreset pc", obs_pc, 0);
        chk("midreset ir", obs_ir, 0);
        chk("midreset ctl", obs_ctl, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_trace("restart", 7, 24);

        // Random programs
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 128; i++) begin
                rnd = $urandom;
                op = rnd[31:28];
                if (op == 4'd5 && rnd[27:26] != 2'b00) op = 4'd3;
                rom[i] = {op, rnd[11:0]};
            end
            apply_reset();
            run_trace($sformatf("rand%0d", it), 7, 80);
        end

        // PC_W = 2 instance: NOOPs wrap the PC 1,2,3,0
        sel = 1;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[1] = 16'hF000;
        rom[3] = 16'hF000;
        apply_reset();
        run_trace("wrap", 2, 19);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
